// File: rtl/ppu_pkg.sv
// Shared PPU sprite definitions: OAM attribute bit positions, slot state encoding
// and the shadow/live slot record.
package ppu_pkg;

    localparam int ATTR_PAL_LSB      = 0;
    localparam int ATTR_PRI          = 5;
    localparam int ATTR_HFLIP        = 6;
    localparam int NUM_SLOTS_DEFAULT = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } slot_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] pat0;
        logic [7:0] pat1;
        logic [7:0] attr;
        logic [7:0] x;
        logic       zero;
    } sprite_slot_t;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_shifter_slot.sv
// One live sprite slot: X countdown, 8-pixel pattern shifter and its current pixel.
module sprite_slot
    import ppu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_px_en,
    input  sprite_slot_t i_load,
    output logic [1:0]   o_px,
    output logic [1:0]   o_pal,
    output logic         o_pri,
    output logic         o_zero
);

    logic        r_valid;
    logic [7:0]  r_cnt;
    logic [3:0]  r_shifts;
    logic [7:0]  r_pat0;
    logic [7:0]  r_pat1;
    logic [7:0]  r_attr;
    logic        r_zero;
    slot_state_t w_state;

    // Slot state is derived from the counters rather than stored separately.
    always_comb begin
        if (!r_valid) begin
            w_state = EMPTY;
        end else if (r_cnt != 8'd0) begin
            w_state = WAIT;
        end else if (r_shifts < 4'd8) begin
            w_state = SHIFT;
        end else begin
            w_state = DONE;
        end
    end

    // Load at line start (wins over px_en), otherwise count down or shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_cnt    <= 8'd0;
            r_shifts <= 4'd0;
            r_pat0   <= 8'd0;
            r_pat1   <= 8'd0;
            r_attr   <= 8'd0;
            r_zero   <= 1'b0;
        end else if (i_start) begin
            r_valid  <= i_load.valid;
            r_cnt    <= i_load.x;
            r_shifts <= 4'd0;
            r_pat0   <= i_load.pat0;
            r_pat1   <= i_load.pat1;
            r_attr   <= i_load.attr;
            r_zero   <= i_load.zero;
        end else if (i_px_en) begin
            case (w_state)
                WAIT: begin
                    r_cnt <= r_cnt - 8'd1;
                end
                SHIFT: begin
                    r_pat0   <= {r_pat0[6:0], 1'b0};
                    r_pat1   <= {r_pat1[6:0], 1'b0};
                    r_shifts <= r_shifts + 4'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Pixel is visible only while shifting.
    always_comb begin
        if (w_state == SHIFT) begin
            o_px = {r_pat1[7], r_pat0[7]};
        end else begin
            o_px = 2'd0;
        end
    end

    assign o_pal  = r_attr[ATTR_PAL_LSB +: 2];
    assign o_pri  = r_attr[ATTR_PRI];
    assign o_zero = r_zero;

endmodule

// File: rtl/sprite_shifter.sv
// Sprite pixel unit: shadow slot bank, live slots, priority mux, pixel X counter
// and sticky sprite-zero hit.
module sprite_shifter
    import ppu_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [SLOT_W-1:0] ld_slot,
    input  logic [7:0]        ld_pat0,
    input  logic [7:0]        ld_pat1,
    input  logic [7:0]        ld_attr,
    input  logic [7:0]        ld_x,
    input  logic              ld_zero,
    input  logic              clr_shadow,
    input  logic              start_line,
    input  logic              px_en,
    input  logic [1:0]        bg_px,
    input  logic              show_left,
    input  logic              clr_hit,
    output logic [1:0]        sp_px,
    output logic [1:0]        sp_pal,
    output logic              sp_pri,
    output logic              sp0_hit
);

    sprite_slot_t r_shadow [NUM_SLOTS];
    sprite_slot_t w_ld_entry;
    logic [7:0]   r_px_x;
    logic [1:0]   w_slot_px   [NUM_SLOTS];
    logic [1:0]   w_slot_pal  [NUM_SLOTS];
    logic         w_slot_pri  [NUM_SLOTS];
    logic         w_slot_zero [NUM_SLOTS];
    logic         w_found;
    logic [1:0]   w_win_px;
    logic [1:0]   w_win_pal;
    logic         w_win_pri;
    logic         w_zero_opaque;
    logic         w_clip;
    logic         w_hit;

    // Flipped sprites are stored pre-reversed so the shifter always shifts left.
    always_comb begin
        w_ld_entry.valid = 1'b1;
        w_ld_entry.attr  = ld_attr;
        w_ld_entry.x     = ld_x;
        w_ld_entry.zero  = ld_zero;
        if (ld_attr[ATTR_HFLIP]) begin
            w_ld_entry.pat0 = rev8(ld_pat0);
            w_ld_entry.pat1 = rev8(ld_pat1);
        end else begin
            w_ld_entry.pat0 = ld_pat0;
            w_ld_entry.pat1 = ld_pat1;
        end
    end

    // Shadow bank; out-of-range ld_slot matches no entry and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (ld && (32'(ld_slot) == i)) begin
                    r_shadow[i] <= w_ld_entry;
                end else if (clr_shadow) begin
                    r_shadow[i].valid <= 1'b0;
                end else begin
                    r_shadow[i] <= r_shadow[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sprite_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_start (start_line),
            .i_px_en (px_en),
            .i_load  (r_shadow[g]),
            .o_px    (w_slot_px[g]),
            .o_pal   (w_slot_pal[g]),
            .o_pri   (w_slot_pri[g]),
            .o_zero  (w_slot_zero[g])
        );
    end

    // Lowest-index opaque slot wins; the zero slot is checked independently.
    always_comb begin
        w_found       = 1'b0;
        w_win_px      = 2'd0;
        w_win_pal     = 2'd0;
        w_win_pri     = 1'b0;
        w_zero_opaque = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!w_found && (w_slot_px[i] != 2'd0)) begin
                w_found   = 1'b1;
                w_win_px  = w_slot_px[i];
                w_win_pal = w_slot_pal[i];
                w_win_pri = w_slot_pri[i];
            end else begin
                w_found = w_found;
            end
            if (w_slot_zero[i] && (w_slot_px[i] != 2'd0)) begin
                w_zero_opaque = 1'b1;
            end else begin
                w_zero_opaque = w_zero_opaque;
            end
        end
    end

    assign w_clip = !show_left && (r_px_x < 8'd8);
    assign w_hit  = w_zero_opaque && (bg_px != 2'd0) && (r_px_x != 8'd255) && !w_clip;

    // Output stage with left-edge clipping.
    always_comb begin
        if (w_clip) begin
            sp_px  = 2'd0;
            sp_pal = 2'd0;
            sp_pri = 1'b0;
        end else begin
            sp_px  = w_win_px;
            sp_pal = w_win_pal;
            sp_pri = w_win_pri;
        end
    end

    // Pixel X counter, saturating at the last column.
    always_ff @(posedge clk) begin
        if (rst || start_line) begin
            r_px_x <= 8'd0;
        end else if (px_en && (r_px_x != 8'd255)) begin
            r_px_x <= r_px_x + 8'd1;
        end else begin
            r_px_x <= r_px_x;
        end
    end

    // Sticky hit flag; a hit beats clr_hit in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp0_hit <= 1'b0;
        end else if (px_en && !start_line && w_hit) begin
            sp0_hit <= 1'b1;
        end else if (clr_hit) begin
            sp0_hit <= 1'b0;
        end else begin
            sp0_hit <= sp0_hit;
        end
    end

endmodule

// File: tb/tb_sprite_shifter.sv
// Directed bench for sprite_shifter with hand-computed pixel and hit expectations.
module tb_sprite_shifter;

    logic       clk = 1'b0;
    logic       rst, ld, ld_zero, clr_shadow, start_line, px_en, show_left, clr_hit;
    logic [2:0] ld_slot;
    logic [7:0] ld_pat0, ld_pat1, ld_attr, ld_x;
    logic [1:0] bg_px, sp_px, sp_pal;
    logic       sp_pri, sp0_hit;
    int         checks = 0;
    int         errors = 0;

    sprite_shifter #(.NUM_SLOTS(6)) dut (
        .clk(clk), .rst(rst), .ld(ld), .ld_slot(ld_slot), .ld_pat0(ld_pat0),
        .ld_pat1(ld_pat1), .ld_attr(ld_attr), .ld_x(ld_x), .ld_zero(ld_zero),
        .clr_shadow(clr_shadow), .start_line(start_line), .px_en(px_en),
        .bg_px(bg_px), .show_left(show_left), .clr_hit(clr_hit),
        .sp_px(sp_px), .sp_pal(sp_pal), .sp_pri(sp_pri), .sp0_hit(sp0_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] s, input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] a, input logic [7:0] x, input logic z);
        ld = 1'b1; ld_slot = s; ld_pat0 = p0; ld_pat1 = p1; ld_attr = a; ld_x = x; ld_zero = z;
        tick();
        ld = 1'b0;
    endtask

    task automatic clrsh();
        clr_shadow = 1'b1;
        tick();
        clr_shadow = 1'b0;
    endtask

    task automatic startl();
        start_line = 1'b1;
        tick();
        start_line = 1'b0;
    endtask

    task automatic pix();
        px_en = 1'b1;
        tick();
        px_en = 1'b0;
    endtask

    task automatic pulse_clr_hit();
        clr_hit = 1'b1;
        tick();
        clr_hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; ld_slot = 3'd0; ld_pat0 = 8'd0; ld_pat1 = 8'd0;
        ld_attr = 8'd0; ld_x = 8'd0; ld_zero = 1'b0; clr_shadow = 1'b0;
        start_line = 1'b0; px_en = 1'b0; bg_px = 2'd0; show_left = 1'b1; clr_hit = 1'b0;
        tick();
        tick();
        chk("reset_px", {6'd0, sp_px}, 8'd0);
        chk("reset_pal", {6'd0, sp_pal}, 8'd0);
        chk("reset_pri", {7'd0, sp_pri}, 8'd0);
        chk("reset_hit", {7'd0, sp0_hit}, 8'd0);
        rst = 1'b0;

        // Basic: single opaque pixel at X 3, palette 2
        clrsh();
        load(3'd0, 8'h80, 8'h80, 8'h02, 8'd3, 1'b0);
        startl();
        for (int x = 0; x < 8; x++) begin
            chk($sformatf("basic_px_x%0d", x), {6'd0, sp_px}, (x == 3) ? 8'd3 : 8'd0);
            chk($sformatf("basic_pal_x%0d", x), {6'd0, sp_pal}, (x == 3) ? 8'd2 : 8'd0);
            pix();
        end

        // Horizontal flip: LSB of plane 0 becomes the first pixel
        clrsh();
        load(3'd0, 8'h01, 8'h00, 8'h40, 8'd0, 1'b0);
        startl();
        for (int x = 0; x < 8; x++) begin
            chk($sformatf("hflip_px_x%0d", x), {6'd0, sp_px}, (x == 0) ? 8'd1 : 8'd0);
            pix();
        end

        // Overlap: slot 0 wins while opaque, then slot 1 shows through
        clrsh();
        load(3'd1, 8'hFF, 8'h00, 8'h01, 8'd10, 1'b0);
        load(3'd0, 8'h00, 8'hF0, 8'h23, 8'd10, 1'b0);
        startl();
        for (int x = 0; x < 19; x++) begin
            if (x >= 9) begin
                chk($sformatf("ovl_px_x%0d", x), {6'd0, sp_px},
                    (x >= 10 && x <= 13) ? 8'd2 : (x >= 14 && x <= 17) ? 8'd1 : 8'd0);
                chk($sformatf("ovl_pal_x%0d", x), {6'd0, sp_pal},
                    (x >= 10 && x <= 13) ? 8'd3 : (x >= 14 && x <= 17) ? 8'd1 : 8'd0);
                chk($sformatf("ovl_pri_x%0d", x), {7'd0, sp_pri},
                    (x >= 10 && x <= 13) ? 8'd1 : 8'd0);
            end
            pix();
        end

        // Sprite-zero hit with left clip: first hit pixel is X 8
        pulse_clr_hit();
        clrsh();
        load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd2, 1'b1);
        bg_px = 2'd1;
        show_left = 1'b0;
        startl();
        for (int x = 0; x < 10; x++) begin
            chk($sformatf("clip_hit_x%0d", x), {7'd0, sp0_hit}, (x > 8) ? 8'd1 : 8'd0);
            if (x == 3) chk("clip_px_x3", {6'd0, sp_px}, 8'd0);
            if (x == 8) chk("clip_px_x8", {6'd0, sp_px}, 8'd1);
            pix();
        end
        show_left = 1'b1;
        pulse_clr_hit();
        chk("hit_cleared", {7'd0, sp0_hit}, 8'd0);
        startl();
        for (int x = 0; x < 4; x++) begin
            chk($sformatf("noclip_hit_x%0d", x), {7'd0, sp0_hit}, (x > 2) ? 8'd1 : 8'd0);
            pix();
        end
        pulse_clr_hit();
        chk("hit_cleared2", {7'd0, sp0_hit}, 8'd0);

        // Last column: pixel shows at X 255 but never produces a hit
        clrsh();
        load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd255, 1'b1);
        startl();
        for (int x = 0; x < 255; x++) begin
            pix();
        end
        chk("edge_px_x255", {6'd0, sp_px}, 8'd1);
        chk("edge_hit_before", {7'd0, sp0_hit}, 8'd0);
        pix();
        chk("edge_hit_after", {7'd0, sp0_hit}, 8'd0);
        bg_px = 2'd0;

        // ld coincident with start_line: old shadow goes live, new data next line
        clrsh();
        load(3'd0, 8'hFF, 8'h00, 8'h00, 8'd0, 1'b0);
        startl();
        ld = 1'b1; ld_slot = 3'd0; ld_pat0 = 8'h00; ld_pat1 = 8'hFF;
        ld_attr = 8'h00; ld_x = 8'd0; ld_zero = 1'b0;
        start_line = 1'b1;
        tick();
        ld = 1'b0;
        start_line = 1'b0;
        chk("same_cycle_old_x0", {6'd0, sp_px}, 8'd1);
        pix();
        chk("same_cycle_old_x1", {6'd0, sp_px}, 8'd1);
        startl();
        chk("next_line_new", {6'd0, sp_px}, 8'd2);
        pix();
        chk("next_line_new_x1", {6'd0, sp_px}, 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midline_rst_px", {6'd0, sp_px}, 8'd0);
        chk("midline_rst_pal", {6'd0, sp_pal}, 8'd0);
        chk("midline_rst_pri", {7'd0, sp_pri}, 8'd0);
        chk("midline_rst_hit", {7'd0, sp0_hit}, 8'd0);
        startl();
        chk("rst_shadow_empty", {6'd0, sp_px}, 8'd0);

        // Out-of-range slot index is ignored
        load(3'd7, 8'hFF, 8'hFF, 8'h03, 8'd0, 1'b0);
        startl();
        chk("oor_slot_ignored", {6'd0, sp_px}, 8'd0);
        load(3'd5, 8'hFF, 8'hFF, 8'h03, 8'd0, 1'b0);
        startl();
        chk("top_slot_px", {6'd0, sp_px}, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_shifter.md
# sprite_shifter

Parametrised sprite pixel unit for the PPU pixel pipeline. It holds up to NUM_SLOTS sprites per scanline, with per-slot X-countdown, pattern shift registers, horizontal flip, priority muxing and sprite-zero hit detection. Slots are loaded during the sprite-fetch window and armed at the start of the next visible line. During that line the unit feeds the palette-index mux alongside the background path.

## Interface
Parameters:
- NUM_SLOTS, 8: sprite slots per line; legal values 1..64.
- SLOT_W, $clog2(NUM_SLOTS) (minimum 1): width of the slot index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ld  in  1  write strobe for the shadow slot ld_slot.
- ld_slot  in  SLOT_W  slot being written; values >= NUM_SLOTS are ignored.
- ld_pat0, ld_pat1  in  8 each  pattern planes 0 and 1, unflipped.
- ld_attr  in  8  OAM attribute: [1:0] palette, [5] behind-background, [6] hflip.
- ld_x  in  8  sprite X position.
- ld_zero  in  1  marks this slot as holding OAM sprite 0.
- clr_shadow  in  1  marks every shadow slot empty (asserted at the start of sprite evaluation).
- start_line  in  1  pulse that copies shadow to live and resets the pixel X counter.
- px_en  in  1  advance one pixel.
- bg_px  in  2  background pixel value for the current pixel.
- show_left  in  1  when 0, sprites are hidden at pixel X 0..7.
- clr_hit  in  1  clears sp0_hit (pre-render line).
- sp_px  out  2  winning sprite pixel; 0 means transparent.
- sp_pal  out  2  palette of the winning sprite.
- sp_pri  out  1  attr[5] of the winning sprite.
- sp0_hit  out  1  sticky sprite-zero hit flag.

## Operation
- Each slot has shadow registers: valid, pat0, pat1, attr, x, zero. ld writes them and sets valid.
- When attr[6]=1, pat0 and pat1 are bit-reversed at write time.
- start_line copies every shadow slot to its live slot and sets px_x=0.
- Live slot states:
  - EMPTY: valid=0.
  - WAIT: cnt!=0.
  - SHIFT: cnt==0 and shifts<8.
  - DONE: after 8 shifts.
- Slot transitions on px_en:
  - WAIT: cnt decrements by 1.
  - SHIFT: both planes shift left by 1 and shifts increments; the 8th shift enters DONE.
  - DONE and EMPTY hold until the next start_line.
- A slot loaded with x=0 enters SHIFT directly. A slot loaded with x=255 shows only its first pixel, at X 255.
- The slot pixel is {pat1[7], pat0[7]} while in SHIFT, and 0 in every other state.
- Winner: the lowest-index slot with a nonzero pixel. Its pixel, palette and priority drive sp_px/sp_pal/sp_pri. With no winner, all three outputs are 0.
- Left clip: when show_left=0 and px_x<8, all outputs are forced to 0. Counters and shifters keep running.
- Sprite-zero hit: on a px_en cycle where all of the following hold, sp0_hit is set and stays set until clr_hit or rst:
  - the live zero slot's pixel is nonzero (regardless of whether it wins);
  - bg_px != 0;
  - px_x != 255;
  - not left-clipped.
- px_x increments on each px_en and saturates at 255.

## Timing
- Outputs are combinational from live state for the current pixel: zero-latency relative to px_en. State advances at the clock edge where px_en=1.
- start_line takes effect at its clock edge; the first px_en may come on the very next cycle.
- ld and start_line in the same cycle: start_line copies the old shadow; the ld value appears on the following line.
- clr_shadow and ld in the same cycle: ld wins for its slot only.
- clr_hit and a hit in the same cycle: the hit wins (sp0_hit=1).
- start_line with px_en in the same cycle: start_line wins and no shift occurs.
- Reset values: all shadow and live slots EMPTY with data 0; px_x=0; sp_px=0, sp_pal=0, sp_pri=0, sp0_hit=0. rst mid-line empties all live slots immediately.

## Structure
- ppu_pkg holds:
  - ATTR_PAL_LSB=0, ATTR_PRI=5, ATTR_HFLIP=6;
  - NUM_SLOTS_DEFAULT=8;
  - the slot_state_t enum {EMPTY, WAIT, SHIFT, DONE};
  - a sprite_slot_t struct.
- Sub-module sprite_slot: one live slot's counter, shifter and state, plus its pixel output. sprite_shifter instantiates NUM_SLOTS of them with a generate loop and adds the shadow bank, priority mux, px_x counter and hit logic.

## Test plan
- Slot 0: x=3, pat0=0x80, pat1=0x80, attr=0x02; start_line, then 8 px_en -> sp_px=3 and sp_pal=2 only at the 4th pixel (X 3); 0 elsewhere.
- Hflip: pat0=0x01, attr[6]=1, x=0 -> sp_px=1 at X 0; 0 at X 1..7.
- Overlap: slot1 x=10 pat0=0xFF; slot0 x=10 pat0=0x00, pat1=0xF0 -> X 10..13 output slot0 (sp_px=2); X 14..17 output slot1 (sp_px=1).
- Hit and clip: zero slot at x=2, pat0=0xFF, bg_px=1, show_left=0 -> sp0_hit rises only at X 8. Repeat with show_left=1 -> rises at X 2. clr_hit -> 0.
- Edge: x=255 opaque with bg_px=1 -> sp_px nonzero at X 255 and sp0_hit stays 0.
- ld and start_line in the same cycle, then rst mid-line -> new data appears only on the next line; after rst all outputs are 0.
